// File: rtl/task_6_subtractor.sv
// task_6_subtractor: board-level bit-serial subtractor.
// A debounced press of the active-low subtract key captures sw1/sw2 and
// computes sw1 - sw2 one bit per clock, LSB first. Captured operands go to
// the red LEDs, the difference to the green LEDs, and the final borrow to
// a dedicated red LED.
//
// Handshake note: there is no valid/ready pair here. The only "request" is
// the one-cycle press pulse; it is accepted only in IDLE and is silently
// dropped (never queued) while ledr_busy is high.
module task_6_subtractor #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             key0_rst,
  input  logic             key1_sub,
  input  logic [WIDTH-1:0] sw1,
  input  logic [WIDTH-1:0] sw2,
  output logic [WIDTH-1:0] ledr1,
  output logic [WIDTH-1:0] ledr2,
  output logic [WIDTH-1:0] ledg,
  output logic             ledr_borrow,
  output logic             ledr_busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             deb_q;
  logic [DW-1:0]    db_cnt_q;
  logic             press_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  // Debounce decision and serial subtract bit, derived from current state.
  logic deb_diff, deb_flip;
  logic capture, shift, finish;
  logic diff_bit, br_next;

  // Key synchronizer: two flops, idle level is released (1).
  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key1_sub;
      sync2_q <= sync1_q;
    end
  end

  // Debounce flip condition: enough consecutive disagreeing samples.
  always_comb begin
    deb_diff = (sync2_q != deb_q);
    deb_flip = deb_diff && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
  end

  // Debounced level, run-length counter and registered press pulse.
  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) begin
      deb_q    <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      press_q <= deb_flip & deb_q;
      if (deb_flip) begin
        deb_q    <= ~deb_q;
        db_cnt_q <= '0;
      end else if (deb_diff) begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Next-state and datapath controls; a press outside IDLE is dropped.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_q) begin
          capture = 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        shift = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One full-subtractor bit on the current LSBs.
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Operand capture, serial shift and result publication.
  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      ledr1       <= '0;
      ledr2       <= '0;
      ledg        <= '0;
      ledr_borrow <= 1'b0;
      ledr_busy   <= 1'b0;
    end else begin
      if (capture) begin
        a_q       <= sw1;
        b_q       <= sw2;
        ledr1     <= sw1;
        ledr2     <= sw2;
        br_q      <= 1'b0;
        cnt_q     <= '0;
        ledr_busy <= 1'b1;
      end else if (shift) begin
        res_q <= {diff_bit, res_q[WIDTH-1:1]};
        a_q   <= {1'b0, a_q[WIDTH-1:1]};
        b_q   <= {1'b0, b_q[WIDTH-1:1]};
        br_q  <= br_next;
        cnt_q <= cnt_q + 1'b1;
      end else if (finish) begin
        ledg        <= res_q;
        ledr_borrow <= br_q;
        ledr_busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_task_6_subtractor.sv
// Testbench for task_6_subtractor: table of operand pairs with hand-computed
// differences, plus directed sequences for glitches, busy-time presses and
// mid-operation reset.
module tb_task_6_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         key0_rst;
  logic         key1_sub;
  logic [W-1:0] sw1, sw2;
  logic [W-1:0] ledr1, ledr2, ledg;
  logic         ledr_borrow, ledr_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
  } vec_t;

  vec_t vecs[8];

  task_6_subtractor #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .key0_rst   (key0_rst),
    .key1_sub   (key1_sub),
    .sw1        (sw1),
    .sw2        (sw2),
    .ledr1      (ledr1),
    .ledr2      (ledr2),
    .ledg       (ledg),
    .ledr_borrow(ledr_borrow),
    .ledr_busy  (ledr_busy)
  );

  // Clock: 10 time-unit period; inputs driven and outputs sampled on negedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the key low for low_cycles, then release; measure the busy window.
  task automatic press(input int low_cycles, output int busy_len, output int rises);
    logic prev;
    busy_len = 0;
    rises    = 0;
    prev     = 1'b0;
    key1_sub = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ledr_busy) busy_len++;
      if (ledr_busy && !prev) rises++;
      prev = ledr_busy;
      if (i == low_cycles - 1) key1_sub = 1'b1;
    end
    key1_sub = 1'b1;
  endtask

  task automatic idle_cycles(input int n, output int busy_seen);
    busy_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ledr_busy) busy_seen++;
    end
  endtask

  initial begin
    int busy_len, rises, seen;
    logic prev;

    vecs[0] = '{8'h04, 8'h03, 8'h01, 1'b0};
    vecs[1] = '{8'h03, 8'h04, 8'hFF, 1'b1};
    vecs[2] = '{8'h14, 8'h13, 8'h01, 1'b0};
    vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[7] = '{8'h5A, 8'hC3, 8'h97, 1'b1};

    // Reset block: low for 3 cycles, outputs must be cleared.
    key0_rst = 1'b0;
    key1_sub = 1'b1;
    sw1      = 8'h3C;
    sw2      = 8'h11;
    repeat (3) @(negedge clk);
    check("rst_ledr1", 32'(ledr1), 32'h0);
    check("rst_ledg", 32'(ledg), 32'h0);
    check("rst_busy", 32'(ledr_busy), 32'h0);
    key0_rst = 1'b1;
    idle_cycles(20, seen);
    check("idle_no_op", 32'(seen), 32'h0);
    check("idle_ledr2", 32'(ledr2), 32'h0);
    check("idle_borrow", 32'(ledr_borrow), 32'h0);

    // Table-driven operations.
    for (int v = 0; v < 8; v++) begin
      sw1 = vecs[v].a;
      sw2 = vecs[v].b;
      press(10, busy_len, rises);
      check($sformatf("v%0d_busy_len", v), 32'(busy_len), 32'd9);
      check($sformatf("v%0d_ledr1", v), 32'(ledr1), 32'(vecs[v].a));
      check($sformatf("v%0d_ledr2", v), 32'(ledr2), 32'(vecs[v].b));
      check($sformatf("v%0d_ledg", v), 32'(ledg), 32'(vecs[v].exp_diff));
      check($sformatf("v%0d_borrow", v), 32'(ledr_borrow), 32'(vecs[v].exp_borrow));
    end

    // Short glitch (2 cycles) must not start an operation.
    sw1 = 8'h22;
    sw2 = 8'h11;
    press(2, busy_len, rises);
    check("glitch_no_busy", 32'(busy_len), 32'h0);
    check("glitch_ledr1", 32'(ledr1), 32'h5A);
    check("glitch_ledg", 32'(ledg), 32'h97);

    // Minimum-length press, release and re-press landing inside SUB.
    sw1 = 8'h80;
    sw2 = 8'h01;
    rises = 0;
    prev  = 1'b0;
    key1_sub = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ledr_busy && !prev) begin
        rises++;
        sw1 = 8'hFF;
        sw2 = 8'hFF;
      end
      prev = ledr_busy;
      if (i == 3) key1_sub = 1'b1;
      if (i == 7) key1_sub = 1'b0;
    end
    key1_sub = 1'b1;
    idle_cycles(12, seen);
    check("busy_press_rises", 32'(rises), 32'd1);
    check("busy_press_after", 32'(seen), 32'h0);
    check("busy_press_ledg", 32'(ledg), 32'h7F);
    check("busy_press_borrow", 32'(ledr_borrow), 32'h0);
    check("busy_press_ledr1", 32'(ledr1), 32'h80);
    check("busy_press_ledr2", 32'(ledr2), 32'h01);

    // Reset in the middle of an operation.
    sw1 = 8'h10;
    sw2 = 8'h01;
    key1_sub = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (ledr_busy) seen = 1;
    end
    check("mid_rst_started", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    key0_rst = 1'b0;
    #1;
    check("mid_rst_ledr1", 32'(ledr1), 32'h0);
    check("mid_rst_ledr2", 32'(ledr2), 32'h0);
    check("mid_rst_ledg", 32'(ledg), 32'h0);
    check("mid_rst_busy", 32'(ledr_busy), 32'h0);
    key1_sub = 1'b1;
    repeat (2) @(negedge clk);
    key0_rst = 1'b1;
    idle_cycles(20, seen);
    check("post_rst_no_op", 32'(seen), 32'h0);
    check("post_rst_ledg", 32'(ledg), 32'h0);
    check("post_rst_borrow", 32'(ledr_borrow), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
